// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the Otter instruction-fetch stage.
package otter_fetch_pkg;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    localparam int          PC_STEP           = 4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/otter_fetch_if.sv
// Fetch-stage buses: instruction-memory request/response and the decode-side buffer port.
interface otter_fetch_if #(
    parameter int XLEN = 32
);
    // Handshake rule for every valid/ready pair here: a transfer happens on a rising
    // edge where valid && ready; the sender holds its payload while valid && !ready.
    // The response channel has no ready: the fetch unit always accepts it.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready
    );

endinterface

// File: rtl/otter_fetch_buf.sv
// One-entry holding register between fetch and decode.
// Priority is flush > load > drain, so a load in the drain cycle keeps the entry valid.
module otter_fetch_buf
    import otter_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            load,
    input  logic            drain,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/otter_fetch_unit.sv
// Otter fetch stage: owns the PC, issues one outstanding imem request at a time,
// and hands fetched words to decode through a single-entry buffer.
module otter_fetch_unit
    import otter_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    output logic [XLEN-1:0] pc_plus4,
    otter_fetch_if.master   bus,
    output fetch_state_t    dbg_state
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            post_rst_q;
    logic            buf_valid;
    logic            req_fire;
    logic            load;
    logic            drain;

    assign pc_plus4  = pc_q + XLEN'(PC_STEP);
    assign dbg_state = state_q;

    // Combinational through if_ready so a request can issue in the cycle the buffer drains.
    assign bus.imem_req_valid = !rst && (state_q == S_REQ) && (!buf_valid || bus.if_ready);
    assign bus.imem_addr      = pc_q;
    assign bus.if_valid       = buf_valid;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign load     = (state_q == S_WAIT) && bus.imem_rsp_valid && !drop_q && !redirect;
    assign drain    = buf_valid && bus.if_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    drop_d  = redirect;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase
        // Redirect wins over the sequential step; targets are forced word-aligned.
        if (redirect) begin
            pc_d = next_pc & ~XLEN'(3);
        end else if (load) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_VEC;
            drop_q     <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (req_fire) begin
                post_rst_q <= 1'b0;
            end
        end
    end

    otter_fetch_buf #(
        .XLEN (XLEN)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .load       (load),
        .drain      (drain),
        .load_pc    (pc_q),
        .load_instr (bus.imem_rsp_data),
        .valid      (buf_valid),
        .pc         (bus.if_pc),
        .instr      (bus.if_instr)
    );

    // A stale response left over from before a reset is legal until the first new request.
    a_no_rsp_in_req : assert property (@(posedge clk) disable iff (rst)
        !((state_q == S_REQ) && bus.imem_rsp_valid && !post_rst_q));

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed bench for otter_fetch_unit: memory model, scoreboard monitor, final report.
module tb_otter_fetch_unit;
    import otter_fetch_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic         clk;
    logic         rst;
    logic [31:0]  next_pc;
    logic         redirect;
    logic [31:0]  pc_plus4;
    fetch_state_t dbg_state;
    int           mem_lat;
    int           n_vec;
    int           n_fail;
    logic         outst;

    logic [63:0]  exp_q[$];

    otter_fetch_if #(.XLEN(32)) bus ();

    otter_fetch_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .next_pc   (next_pc),
        .redirect  (redirect),
        .pc_plus4  (pc_plus4),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, pc ^ K});
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        redirect = 1'b0;
        bus.if_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_if_valid",  32'(bus.if_valid),       32'd0);
        check("rst_if_pc",     bus.if_pc,               32'h0);
        check("rst_if_instr",  bus.if_instr,            32'h0);
        check("rst_addr",      bus.imem_addr,           32'h0);
        check("rst_pc_plus4",  pc_plus4,                32'h4);
        check("rst_state",     32'(dbg_state),          32'(S_REQ));
        tick();
        rst = 1'b0;
    endtask

    // Waits for the next accepted request and checks its address.
    task automatic expect_accept(input string name, input logic [31:0] exp_addr, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.imem_req_valid && bus.imem_req_ready) && n < budget);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check(name, bus.imem_addr, exp_addr);
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got no request, want addr %h", name, exp_addr);
        end
    endtask

    // Waits for an accepted request at a given address (earlier ones are skipped).
    task automatic wait_addr(input logic [31:0] addr, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.imem_req_valid && bus.imem_req_ready && bus.imem_addr == addr) && n < budget);
        if (!(bus.imem_req_valid && bus.imem_req_ready && bus.imem_addr == addr)) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_addr: got timeout, want request at %h", addr);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (exp_q.size() != 0 && n < budget);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- memory model ----------------
    initial begin
        logic [31:0] a;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                a = bus.imem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = a ^ K;
                @(posedge clk);
                #1;
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    // ---------------- outstanding-request checker ----------------
    initial begin
        outst = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_rsp_valid) outst = 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("one_outstanding", 32'(outst), 32'd0);
                outst = 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !redirect && bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got pc %h, want none", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc",    bus.if_pc,    e[63:32]);
                    check("xfer_instr", bus.if_instr, e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec    = 0;
        n_fail   = 0;
        mem_lat  = 1;
        next_pc  = '0;
        redirect = 1'b0;
        rst      = 1'b1;
        bus.if_ready       = 1'b0;
        bus.imem_req_ready = 1'b1;

        // 1: free run, first instruction two cycles after reset
        reset_dut();
        bus.if_ready = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        @(negedge clk);
        check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1_addr",      bus.imem_addr,           32'h0);
        @(negedge clk);
        check("t1_lat_c1", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        check("t1_lat_c2", 32'(bus.if_valid), 32'd1);
        wait_drain(40);

        // 2: decode backpressure holds the buffer and blocks requests
        reset_dut();
        push_exp(32'h0);
        push_exp(32'h4);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(bus.if_valid),       32'd1);
            check("t2_hold_pc",    bus.if_pc,               32'h0);
            check("t2_hold_instr", bus.if_instr,            K);
            check("t2_no_req",     32'(bus.imem_req_valid), 32'd0);
            tick();
        end
        bus.if_ready = 1'b1;
        expect_accept("t2_next_addr", 32'h4, 10);
        wait_drain(40);

        // 3: redirect while a request is outstanding
        reset_dut();
        mem_lat = 2;
        bus.if_ready = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        wait_addr(32'h8, 40);
        tick();
        redirect = 1'b1;
        next_pc  = 32'h100;
        @(negedge clk);
        check("t3_ifv_redirect", 32'(bus.if_valid), 32'd0);
        tick();
        redirect = 1'b0;
        push_exp(32'h100);
        @(negedge clk);
        check("t3_ifv_discard", 32'(bus.if_valid), 32'd0);
        expect_accept("t3_addr", 32'h100, 10);
        check("t3_ifv_after", 32'(bus.if_valid), 32'd0);
        wait_drain(40);

        // 4: redirect with a full buffer, then redirect coincident with a response
        reset_dut();
        mem_lat = 1;
        tick();
        tick();
        @(negedge clk);
        check("t4_full_valid", 32'(bus.if_valid), 32'd1);
        check("t4_full_pc",    bus.if_pc,         32'h0);
        tick();
        redirect = 1'b1;
        next_pc  = 32'h203;
        @(negedge clk);
        check("t4_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("t4_flushed",  32'(bus.if_valid),       32'd0);
        check("t4_addr",     bus.imem_addr,           32'h200);
        check("t4_pc_plus4", pc_plus4,                32'h204);
        check("t4_req",      32'(bus.imem_req_valid), 32'd1);
        tick();
        redirect = 1'b1;
        next_pc  = 32'h300;
        bus.if_ready = 1'b1;
        @(negedge clk);
        check("t4_rsp_redirect_valid", 32'(bus.if_valid), 32'd0);
        tick();
        redirect = 1'b0;
        push_exp(32'h300);
        @(negedge clk);
        check("t4_discard_valid", 32'(bus.if_valid), 32'd0);
        check("t4_addr2",         bus.imem_addr,     32'h300);
        wait_drain(40);

        // 5: PC wraps at the top of the address space
        bus.imem_req_ready = 1'b0;
        reset_dut();
        redirect = 1'b1;
        next_pc  = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("t5_addr",      bus.imem_addr,           32'hFFFF_FFFC);
        check("t5_pc_plus4",  pc_plus4,                32'h0);
        check("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
        tick();
        bus.imem_req_ready = 1'b1;
        bus.if_ready       = 1'b1;
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0);
        wait_drain(40);

        // 6: reset in the middle of an outstanding request
        reset_dut();
        mem_lat = 2;
        bus.if_ready = 1'b1;
        expect_accept("t6_first_addr", 32'h0, 10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        check("t6_stale_rsp_seen", 32'(bus.imem_rsp_valid), 32'd1);
        check("t6_if_valid", 32'(bus.if_valid), 32'd0);
        check("t6_if_pc",    bus.if_pc,         32'h0);
        check("t6_if_instr", bus.if_instr,      32'h0);
        check("t6_addr",     bus.imem_addr,     32'h0);
        check("t6_state",    32'(dbg_state),    32'(S_REQ));
        tick();
        bus.imem_req_ready = 1'b1;
        push_exp(32'h0);
        expect_accept("t6_addr_after", 32'h0, 10);
        check("t6_no_load", 32'(bus.if_valid), 32'd0);
        wait_drain(40);

        bus.if_ready = 1'b0;
        tick();
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
